// File: rtl/prime_prefetch.sv
`timescale 1ns/1ps
// prime_prefetch: autonomously requests successive primes from primogen and
// stages them in a small first-word-fall-through FIFO for a downstream reader.
// Only one request is ever outstanding, and a request is only issued when a
// FIFO slot is guaranteed free, so the push side never sees a full FIFO.
module prime_prefetch #(
  parameter int DEPTH    = 4,
  parameter int DROP_ONE = 1,
  parameter int W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         gen_go,
  input  logic                         gen_ready,
  input  logic                         gen_error,
  input  logic [W-1:0]                 gen_res,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err,
  output logic                         idle
);

  localparam int            CW      = $clog2(DEPTH+1);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit            DROP    = (DROP_ONE != 0);

  typedef enum logic [2:0] {
    WAIT_INIT,
    WAIT_SPACE,
    REQ,
    WAIT_DROP,
    WAIT_RES,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push;
  logic           pop;
  logic [CW-1:0]  count_after_pop;

  // Head is read straight from storage, so a push is visible one cycle later.
  assign rd_valid        = (count != '0);
  assign rd_data         = mem[rd_ptr];
  assign pop             = rd_en && rd_valid;
  assign count_after_pop = count - CW'(pop);

  // A response is stored unless it carries an error or is the discarded
  // post-reset value 1.
  always_comb begin
    push = 1'b0;
    case (state)
      WAIT_INIT: push = gen_ready && !gen_error && !(DROP && (gen_res == W'(1)));
      WAIT_RES:  push = gen_ready && !gen_error;
      default:   push = 1'b0;
    endcase
  end

  // Request sequencer: one outstanding request, gen_go and idle registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= WAIT_INIT;
      gen_go <= 1'b0;
      err    <= 1'b0;
      idle   <= 1'b0;
    end else begin
      gen_go <= 1'b0;
      case (state)
        WAIT_INIT: begin
          if (gen_ready) begin
            idle <= 1'b1;
            if (gen_error) begin
              state <= DONE;
              err   <= 1'b1;
            end else begin
              state <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          // Space is judged after this cycle's pop so a freed slot is reused at once.
          if (count_after_pop < DEPTH_C) begin
            state  <= REQ;
            gen_go <= 1'b1;
            idle   <= 1'b0;
          end
        end
        REQ: begin
          state <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!gen_ready) state <= WAIT_RES;
        end
        WAIT_RES: begin
          if (gen_ready) begin
            idle <= 1'b1;
            if (gen_error) begin
              state <= DONE;
              err   <= 1'b1;
            end else begin
              state <= WAIT_SPACE;
            end
          end
        end
        DONE: begin
          idle <= 1'b1;
        end
        default: begin
          state <= WAIT_INIT;
          idle  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // FIFO storage holds data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gen_res;
  end

endmodule

// File: tb/tb_prime_prefetch.sv
`timescale 1ns/1ps
// Bench for prime_prefetch: two instances (DROP_ONE=1 and DROP_ONE=0), each fed
// by a behavioural primogen model with fixed response latency and an optional
// error on a chosen request.
module tb_prime_prefetch;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int NP    = 20;
  localparam int LAT   = 2;
  localparam logic [W-1:0] PR [NP] = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd7, 16'd11,
                                       16'd13, 16'd17, 16'd19, 16'd23, 16'd29,
                                       16'd31, 16'd37, 16'd41, 16'd43, 16'd47,
                                       16'd53, 16'd59, 16'd61, 16'd67};

  typedef struct {
    logic         pop;
    logic [W-1:0] head;
    logic [2:0]   cnt;
    int           gos;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         go       [2];
  logic         rdy      [2];
  logic         gerr     [2];
  logic         rd_en    [2];
  logic         rd_valid [2];
  logic         err_o    [2];
  logic         idle     [2];
  logic [W-1:0] res      [2];
  logic [W-1:0] rd_data  [2];
  logic [2:0]   count    [2];
  int           go_cnt   [2];
  int           err_at   [2];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : ch
    int   nreq;
    int   idx;
    int   cnt;
    logic busy;

    prime_prefetch #(.DEPTH(DEPTH), .DROP_ONE(g == 0 ? 1 : 0), .W(W)) u_dut (
      .clk       (clk),
      .rst       (rst_n),
      .gen_go    (go[g]),
      .gen_ready (rdy[g]),
      .gen_error (gerr[g]),
      .gen_res   (res[g]),
      .rd_en     (rd_en[g]),
      .rd_data   (rd_data[g]),
      .rd_valid  (rd_valid[g]),
      .count     (count[g]),
      .err       (err_o[g]),
      .idle      (idle[g])
    );

    // primogen model: ready high with 1 after reset; go drops ready, result after LAT+1 cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdy[g]  <= 1'b1;
        res[g]  <= PR[0];
        gerr[g] <= 1'b0;
        busy    <= 1'b0;
        cnt     <= 0;
        nreq    <= 0;
        idx     <= 0;
      end else if (go[g] && rdy[g] && !busy) begin
        rdy[g] <= 1'b0;
        busy   <= 1'b1;
        cnt    <= LAT;
        nreq   <= nreq + 1;
      end else if (busy) begin
        if (cnt == 0) begin
          busy   <= 1'b0;
          rdy[g] <= 1'b1;
          idx    <= idx + 1;
          res[g] <= PR[(idx + 1) % NP];
          if (nreq == err_at[g]) gerr[g] <= 1'b1;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end

    // count gen_go pulses since reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     go_cnt[g] <= 0;
      else if (go[g]) go_cnt[g] <= go_cnt[g] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pop1(input int g);
    rd_en[g] = 1'b1;
    @(negedge clk);
    rd_en[g] = 1'b0;
  endtask

  initial begin
    vec_t         vt [5];
    logic [W-1:0] got [12];
    logic [W-1:0] s4_exp [3];
    int           n;
    int           bad;
    int           k;

    rd_en[0]  = 1'b0;
    rd_en[1]  = 1'b0;
    err_at[0] = 0;
    err_at[1] = 0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_go",       go[0],       0);
    check("rst_count",    count[0],    0);
    check("rst_rd_valid", rd_valid[0], 0);
    check("rst_err",      err_o[0],    0);
    check("rst_idle",     idle[0],     0);

    // Scenario 1: fill with no reader
    rst_n = 1'b1;
    k = 0;
    while (k < 400 && !(go_cnt[0] == 4 && count[0] == 4 && idle[0])) begin
      @(negedge clk);
      k++;
    end
    check("s1_fill_in_time", k < 400, 1);
    repeat (200) @(negedge clk);
    check("s1_go_pulses", go_cnt[0],   4);
    check("s1_count",     count[0],    4);
    check("s1_idle",      idle[0],     1);
    check("s1_rd_valid",  rd_valid[0], 1);
    check("s1_head",      rd_data[0],  2);

    // Scenario 4: DROP_ONE=0 instance keeps the leading 1
    check("s4_count",  count[1],  4);
    check("s4_go_cnt", go_cnt[1], 3);
    s4_exp[0] = 16'd1;
    s4_exp[1] = 16'd2;
    s4_exp[2] = 16'd3;
    for (int i = 0; i < 3; i++) begin
      check("s4_head", rd_data[1], s4_exp[i]);
      pop1(1);
    end

    // Scenario 2: single pops from a full FIFO, refill after each
    vt[0] = '{1'b1, 16'd2, 3'd4, 4};
    vt[1] = '{1'b0, 16'd3, 3'd4, 5};
    vt[2] = '{1'b1, 16'd3, 3'd4, 5};
    vt[3] = '{1'b1, 16'd5, 3'd4, 6};
    vt[4] = '{1'b0, 16'd7, 3'd4, 7};
    for (int v = 0; v < 5; v++) begin
      check("s2_head",   rd_data[0], vt[v].head);
      check("s2_count",  count[0],   vt[v].cnt);
      check("s2_go_cnt", go_cnt[0],  vt[v].gos);
      if (vt[v].pop) begin
        pop1(0);
        k = 0;
        while (k < 100 && !(count[0] == 4 && idle[0])) begin
          @(negedge clk);
          k++;
        end
        check("s2_refill_in_time", k < 100, 1);
      end
    end

    // Scenario 3: continuous reader sees an unbroken prime stream
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    rd_en[0] = 1'b1;
    n   = 0;
    bad = 0;
    k   = 0;
    while (n < 12 && k < 3000) begin
      @(negedge clk);
      k++;
      if (count[0] == 0 && rd_valid[0]) bad++;
      if (rd_valid[0]) begin
        got[n] = rd_data[0];
        n++;
      end
    end
    rd_en[0] = 1'b0;
    check("s3_stream_in_time", n, 12);
    check("s3_valid_when_empty", bad, 0);
    for (int i = 0; i < 12; i++) check("s3_stream", got[i], PR[i + 1]);

    // Scenario 5: primogen error on the third request
    rst_n = 1'b0;
    err_at[0] = 3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 400 && !err_o[0]) begin
      @(negedge clk);
      k++;
    end
    check("s5_err_in_time", k < 400, 1);
    repeat (50) @(negedge clk);
    check("s5_count",  count[0],   2);
    check("s5_err",    err_o[0],   1);
    check("s5_idle",   idle[0],    1);
    check("s5_go_cnt", go_cnt[0],  3);
    check("s5_head0",  rd_data[0], 2);
    pop1(0);
    check("s5_head1",  rd_data[0], 3);
    pop1(0);
    check("s5_empty_valid", rd_valid[0], 0);
    check("s5_empty_count", count[0],    0);
    rd_en[0] = 1'b1;
    repeat (3) @(negedge clk);
    rd_en[0] = 1'b0;
    check("s5_pop_empty_count", count[0],    0);
    check("s5_pop_empty_valid", rd_valid[0], 0);
    check("s5_err_sticky",      err_o[0],    1);
    check("s5_no_more_go",      go_cnt[0],   3);
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_rst_err",  err_o[0], 0);
    check("s5_async_rst_idle", idle[0],  0);
    err_at[0] = 0;

    // Scenario 6: asynchronous reset while waiting for a result with count=2
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 400 && !(count[0] == 2 && !rdy[0])) begin
      @(negedge clk);
      k++;
    end
    check("s6_reach_wait_res", k < 400, 1);
    @(negedge clk);
    check("s6_pre_count", count[0], 2);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_go",       go[0],       0);
    check("s6_rst_count",    count[0],    0);
    check("s6_rst_rd_valid", rd_valid[0], 0);
    check("s6_rst_err",      err_o[0],    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 100 && !rd_valid[0]) begin
      @(negedge clk);
      k++;
    end
    check("s6_restart_in_time", k < 100, 1);
    check("s6_restart_head", rd_data[0], 2);

    // Reset while gen_go is high clears it immediately
    k = 0;
    while (k < 100 && !go[0]) begin
      @(negedge clk);
      k++;
    end
    check("s6_go_seen", go[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_go_high", go[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
